// File: rtl/cpu_mem_arbiter.sv
// Shared memory bus sequencer for the CPU: fetch, optional load/store, then a
// single release cycle per step, with a per-access no-ack timeout.
module cpu_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        dm_rd,
  input  logic        dm_wr,
  output logic [31:0] dm_rdata,
  output logic        cpu_stall,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DATA    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic            in_access;
  logic            timeout_hit;
  logic            done;

  assign in_access   = (state == FETCH) || (state == DATA);
  // An ack on the abort cycle takes priority, so the timeout only fires without one.
  assign timeout_hit = in_access && !bus_ack && (to_cnt == TO_W'(TIMEOUT - 1));
  assign done        = in_access && (bus_ack || timeout_hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      // Staying in an access state implies no ack, so only waits are counted.
      if (!in_access || state_next != state) to_cnt <= '0;
      else                                   to_cnt <= to_cnt + TO_W'(1);

      if (state == FETCH && done)           if_rdata <= bus_ack ? bus_rdata : '0;
      if (state == DATA && done && !dm_wr)  dm_rdata <= bus_ack ? bus_rdata : '0;
      if (timeout_hit)                      bus_err  <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (done) state_next = (dm_rd || dm_wr) ? DATA : RELEASE;
      DATA:    if (done) state_next = RELEASE;
      RELEASE: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    case (state)
      FETCH: begin
        bus_addr = if_addr;
        bus_rd   = !rst;
      end
      DATA: begin
        bus_addr = dm_addr;
        if (dm_wr) begin
          bus_wr    = !rst;
          bus_wdata = dm_wdata;
        end else begin
          bus_rd = !rst;
        end
      end
      default: ;
    endcase
  end

  // The core's reset is gated by !cpu_stall, so reset must never stall.
  assign cpu_stall = !rst && (state != RELEASE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a bus responder with per-step wait counts
// and a scoreboard of the captured instruction, load data and error flag.
module tb_cpu_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        dm_rd, dm_wr, cpu_stall;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_rd, bus_wr, bus_ack, bus_err;

  cpu_mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_rdata(dm_rdata), .cpu_stall(cpu_stall),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t    sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_if  = '0;
  logic [31:0] exp_dm  = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_compare(input string tag, input logic [31:0] obs);
    sb_item_t it;
    check({"sb_nonempty_", tag}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check({tag, "/", it.tag}, obs, it.val);
    end
  endtask

  // One CPU step: fw/dw are wait cycles before ack in FETCH/DATA (>= TIMEOUT means never).
  task automatic run_step(input logic [31:0] pc, input logic rd, input logic wr,
                          input logic [31:0] da, input logic [31:0] wd,
                          input int fw, input logic [31:0] fdat,
                          input int dw, input logic [31:0] ddat);
    int          flen, dlen, k;
    logic        acc, fab, dab;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_ctl;
    acc  = rd | wr;
    fab  = (fw >= TIMEOUT);
    flen = fab ? TIMEOUT : fw + 1;
    dab  = acc && (dw >= TIMEOUT);
    dlen = !acc ? 0 : (dab ? TIMEOUT : dw + 1);
    exp_if = fab ? 32'h0 : fdat;
    if (acc && !wr) exp_dm = dab ? 32'h0 : ddat;
    if (fab || dab) exp_err = 1'b1;
    sb.push_back('{tag: "if_rdata", val: exp_if});
    sb.push_back('{tag: "dm_rdata", val: exp_dm});
    sb.push_back('{tag: "bus_err",  val: {31'b0, exp_err}});

    if_addr = pc; dm_rd = rd; dm_wr = wr; dm_addr = da; dm_wdata = wd;
    for (int c = 0; c < flen + dlen; c++) begin
      if (c < flen) begin
        k         = c;
        bus_ack   = (k == fw);
        bus_rdata = (k == fw) ? fdat : (32'hBAD0_0000 | 32'(c));
        e_addr    = pc;
        e_wdata   = 32'h0;
        e_ctl     = 3'b110;
      end else begin
        k         = c - flen;
        bus_ack   = (k == dw);
        bus_rdata = (k == dw) ? ddat : (32'hBAD1_0000 | 32'(k));
        e_addr    = da;
        e_wdata   = wr ? wd : 32'h0;
        e_ctl     = wr ? 3'b101 : 3'b110;
      end
      #1;
      check("stall_rd_wr", {29'b0, cpu_stall, bus_rd, bus_wr}, {29'b0, e_ctl});
      check("bus_addr", bus_addr, e_addr);
      check("bus_wdata", bus_wdata, e_wdata);
      tick();
    end

    // Release cycle: a stray ack here must be ignored.
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_0000;
    #1;
    check("release_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h0);
    check("release_addr", bus_addr, 32'h0);
    sb_compare("if_rdata", if_rdata);
    sb_compare("dm_rdata", dm_rdata);
    sb_compare("bus_err", {31'b0, bus_err});
    tick();
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    tick();
    tick();
    check("rst_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rst = 1'b0; if_addr = 32'h10;
    #1;
    check("post_rst_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h6);
    check("post_rst_addr", bus_addr, 32'h10);

    // Fetch-only steps, zero wait.
    run_step(32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0340_d809, 0, 32'h0);
    run_step(32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0013, 0, 32'h0);
    // Load with two wait cycles in each phase.
    run_step(32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h0340_d809, 2, 32'h1234_5678);
    // Store, zero wait; then load+store together where the store wins.
    run_step(32'h18, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 0, 32'h1111_2222, 0, 32'h9999_9999);
    run_step(32'h1c, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 1, 32'h3333_4444, 1, 32'h7777_7777);
    // Ack on the abort cycle completes normally; then a fetch timeout; then a load timeout.
    run_step(32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'hABCD_0001, 0, 32'h0);
    run_step(32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 9, 32'hABCD_0002, 0, 32'h0);
    run_step(32'h28, 1'b1, 1'b0, 32'h280, 32'h0, 0, 32'h600D_F00D, 9, 32'h0000_0001);
    run_step(32'h2c, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0013, 0, 32'h0);

    // Reset during a DATA wait drops the access.
    if_addr = 32'h30; dm_rd = 1'b1; dm_wr = 1'b0; dm_addr = 32'h300;
    bus_ack = 1'b1; bus_rdata = 32'h0000_1111;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'hBAD2_0000;
    #1;
    check("mid_data_addr", bus_addr, 32'h300);
    check("mid_data_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h6);
    tick();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    check("rst_in_data_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h0);
    tick();
    rst = 1'b0; bus_ack = 1'b0;
    #1;
    check("after_rst_ctl", {29'b0, cpu_stall, bus_rd, bus_wr}, 32'h6);
    check("after_rst_addr", bus_addr, 32'h30);
    check("after_rst_dm_rdata", dm_rdata, 32'h0);
    check("after_rst_if_rdata", if_rdata, 32'h0);
    check("after_rst_bus_err", {31'b0, bus_err}, 32'h0);
    exp_if = '0; exp_dm = '0; exp_err = 1'b0;
    run_step(32'h30, 1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0000_2222, 1, 32'h4444_5555);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
